mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared byte memory: instruction fetch (read-only) and data (read/write).
- Serialises requests onto the single memory accessor (read, write, address, write_value, read_value, ready).
- Holds each strobe until ready is seen, waits for ready to clear, then returns the result with a one-cycle done pulse.
- Sits between the risc1 core front-end/load-store logic and the fixed memory.

Parameters:
ADDR_W, 8, address width (matches the memory accessor address)
DATA_W, 8, data width (one byte)
TIMEOUT_CYCLES, 64, cycles to wait for mem_ready edges before aborting (only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  single clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
f_req  in  1  fetch request; held with f_addr stable until f_done or f_err
f_addr  in  ADDR_W  fetch address
f_rdata  out  DATA_W  fetch read data; valid while f_done=1
f_done  out  1  one-cycle completion pulse for fetch
f_err  out  1  one-cycle timeout pulse for fetch (0 without macro)
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_done or d_err
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  data write value
d_rdata  out  DATA_W  data read value; valid while d_done=1
d_done  out  1  one-cycle completion pulse for data
d_err  out  1  one-cycle timeout pulse for data (0 without macro)
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_W  memory address
mem_write_value  out  DATA_W  memory write data
mem_read_value  in  DATA_W  memory read data
mem_ready  in  1  memory ready, level; synchronous to clk
busy  out  1  1 in any state other than IDLE
grant  out  1  owner of current or last transaction: 0=fetch, 1=data

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0: strobes, address, write value, rdata, done, err, busy.
  - Round-robin pointer last=1 (data), so fetch wins the first tie.
  - Reset mid-transaction aborts it: strobes drop immediately and no done is issued.
- States: IDLE -> ACCESS -> RELEASE -> IDLE.
- IDLE:
  - Eligible requesters: f_req/d_req, excluding any requester whose done/err is high this cycle (drops the stale request).
  - Grant: if one is eligible, grant it; if both, grant the one != last.
  - On grant, register mem_address, mem_write_value (data writes only, else 0), grant, last.
  - Next cycle: mem_read=1 (fetch, or data with d_we=0) or mem_write=1 (data with d_we=1); state=ACCESS; busy=1.
- ACCESS:
  - Strobe held high every cycle until mem_ready=1 is sampled.
  - On that cycle, capture mem_read_value into the granted requester's rdata (reads only), drop the strobe next cycle, go to RELEASE.
  - Strobe is never asserted for 0 cycles; exactly one of mem_read/mem_write is ever high.
- RELEASE:
  - Strobes 0. Wait for mem_ready=0.
  - Then pulse the granted requester's done for exactly one cycle, coincident with return to IDLE (busy=0 in that cycle).
- Latency: with mem_ready rising 1 cycle after the strobe and falling 1 cycle after the strobe drops, request-to-done is 4 cycles.
  - Back-to-back transactions for alternating requesters start one cycle apart from done.
- rdata holds its value after done until the next read completion for that requester.
- Address/data are truncated or zero-extended to ADDR_W/DATA_W as registered; no arithmetic on addresses.
- Requester changing inputs while req is held: undefined; this is a bench assertion.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entering ACCESS or RELEASE and increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES-1 without the awaited mem_ready level forces strobes 0 and pulses the owner's err for one cycle instead of done.
  - The state returns to IDLE; last is updated as for a normal completion.
- Undefined: no counter; ACCESS/RELEASE wait indefinitely; f_err and d_err tied 0.

Test Plan:
- Single fetch read, mem[0x66]=123, f_req with f_addr=0x66 -> mem_read high for 2 cycles, f_done pulse at cycle 4, f_rdata=123, d_done stays 0.
- Data write then read: d_we=1, d_addr=102, d_wdata=0x5A -> mem_write only, d_done; then d_we=0 at the same address -> d_rdata=0x5A.
- Both requesters asserted from reset, each held for two transactions -> grant order fetch, data, fetch, data; no cycle with both strobes high.
- Requester holds req through the done cycle and drops it the next cycle -> no duplicate transaction issued.
- reset_n pulsed low while in ACCESS with mem_write=1 -> mem_write=0 immediately, no done, busy=0; after release, a fresh d_req completes normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready stuck at 0 -> d_err pulse 8 cycles after entering ACCESS, strobe drops, next f_req is serviced normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and handshake sequencer putting fetch and data requests onto the shared byte memory.
// Optional mem_ready watchdog: define MEM_ARB_TIMEOUT_EN (otherwise f_err/d_err stay 0).

module mem_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_done,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_value,
  input  logic [DATA_W-1:0] mem_read_value,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant
);

  // state   | meaning
  // IDLE    | no transaction in flight; arbitrate eligible requests
  // ACCESS  | strobe held high until mem_ready=1 is sampled
  // RELEASE | strobes low, waiting for mem_ready=0 before done
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_write_value_q, mem_write_value_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                f_done_q, f_done_d;
  logic                d_done_q, d_done_d;
  logic                f_err_q, f_err_d;
  logic                d_err_q, d_err_d;

  logic                f_elig, d_elig;
  logic                pick_data;
  logic                timeout_hit;

  // A requester finishing this cycle still shows req high; ignore it so it is not re-served.
  assign f_elig = f_req && !f_done_q && !f_err_q;
  assign d_elig = d_req && !d_done_q && !d_err_q;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != S_IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Watchdog compiled out: constant false for any legal TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_d            = last_q;
    mem_read_d        = mem_read_q;
    mem_write_d       = mem_write_q;
    mem_address_d     = mem_address_q;
    mem_write_value_d = mem_write_value_q;
    f_rdata_d         = f_rdata_q;
    d_rdata_d         = d_rdata_q;
    f_done_d          = 1'b0;
    d_done_d          = 1'b0;
    f_err_d           = 1'b0;
    d_err_d           = 1'b0;
    pick_data         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (f_elig || d_elig) begin
          pick_data         = d_elig && (!f_elig || !last_q);
          grant_d           = pick_data;
          last_d            = pick_data;
          mem_address_d     = pick_data ? d_addr : f_addr;
          mem_write_value_d = (pick_data && d_we) ? d_wdata : '0;
          mem_write_d       = pick_data && d_we;
          mem_read_d        = !(pick_data && d_we);
          state_d           = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) begin
            if (grant_q) begin
              d_rdata_d = mem_read_value;
            end else begin
              f_rdata_d = mem_read_value;
            end
          end
          state_d = S_RELEASE;
        end else if (timeout_hit) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          f_err_d     = !grant_q;
          d_err_d     = grant_q;
          state_d     = S_IDLE;
        end
      end

      S_RELEASE: begin
        if (!mem_ready) begin
          f_done_d = !grant_q;
          d_done_d = grant_q;
          state_d  = S_IDLE;
        end else if (timeout_hit) begin
          f_err_d = !grant_q;
          d_err_d = grant_q;
          state_d = S_IDLE;
        end
      end

      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // last resets to data so that fetch wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      grant_q           <= 1'b0;
      last_q            <= 1'b1;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_address_q     <= '0;
      mem_write_value_q <= '0;
      f_rdata_q         <= '0;
      d_rdata_q         <= '0;
      f_done_q          <= 1'b0;
      d_done_q          <= 1'b0;
      f_err_q           <= 1'b0;
      d_err_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      grant_q           <= grant_d;
      last_q            <= last_d;
      mem_read_q        <= mem_read_d;
      mem_write_q       <= mem_write_d;
      mem_address_q     <= mem_address_d;
      mem_write_value_q <= mem_write_value_d;
      f_rdata_q         <= f_rdata_d;
      d_rdata_q         <= d_rdata_d;
      f_done_q          <= f_done_d;
      d_done_q          <= d_done_d;
      f_err_q           <= f_err_d;
      d_err_q           <= d_err_d;
    end
  end

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_write_value = mem_write_value_q;
  assign f_rdata         = f_rdata_q;
  assign d_rdata         = d_rdata_q;
  assign f_done          = f_done_q;
  assign d_done          = d_done_q;
  assign f_err           = f_err_q;
  assign d_err           = d_err_q;
  assign grant           = grant_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for mem_arbiter against a simple byte memory model.
// The memory's ready follows either strobe with one cycle of delay; 'stuck' holds it low.

module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_rdata;
  logic          f_done, f_err;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done, d_err;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_value;
  logic [DW-1:0] mem_read_value;
  logic          mem_ready;
  logic          busy, grant;

  logic [DW-1:0] mem [256];
  logic          stuck = 1'b0;
  logic          pl_en = 1'b0;
  logic [7:0]    pl_addr = '0;
  logic [7:0]    pl_data = '0;

  int checks = 0;
  int errors = 0;
  int excl_viol = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_value(mem_write_value), .mem_read_value(mem_read_value),
    .mem_ready(mem_ready), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_ready <= (mem_read | mem_write) & ~stuck;
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_write && mem_ready) mem[mem_address] <= mem_write_value;
  end
  assign mem_read_value = mem[mem_address];

  always @(negedge clk) if (mem_read && mem_write) excl_viol++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // lat = edges from the granting edge to the edge after which done/err is seen (-1 if never)
  task automatic do_txn(input bit is_data, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                        output int lat, output int rd_cnt, output int wr_cnt,
                        output bit got_err, output int other_cnt);
    lat = -1; rd_cnt = 0; wr_cnt = 0; got_err = 1'b0; other_cnt = 0;
    repeat (2) @(negedge clk);
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      rd_cnt += int'(mem_read);
      wr_cnt += int'(mem_write);
      other_cnt += is_data ? int'(f_done | f_err) : int'(d_done | d_err);
      if (is_data ? (d_done | d_err) : (f_done | f_err)) begin
        lat = c - 1;
        got_err = is_data ? d_err : f_err;
        break;
      end
    end
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  typedef struct {
    bit         is_data;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, rd_cnt, wr_cnt, other_cnt, n, fcnt, dcnt, cnt;
    bit got_err;
    int order[4];
    int gnts[4];
    string nm;

    // for writes, exp_rdata is the value d_rdata must still hold from the last data read
    vecs[0] = '{1'b0, 1'b0, 8'h66, 8'h00, 8'd123};
    vecs[1] = '{1'b1, 1'b1, 8'd102, 8'h5A, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 8'd102, 8'h00, 8'h5A};
    vecs[3] = '{1'b0, 1'b0, 8'h66, 8'h00, 8'h5A};
    vecs[4] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hC3};
    vecs[5] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h5A};
    vecs[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00};
    vecs[7] = '{1'b1, 1'b1, 8'h00, 8'hFF, 8'h00};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hFF};
    vecs[9] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hC3};

    #2 reset_n = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wval", mem_write_value, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_f_done", f_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_f_err", f_err, 0);
    chk("rst_d_err", d_err, 0);
    chk("rst_grant", grant, 0);

    preload(8'h66, 8'd123);
    preload(8'h10, 8'hC3);
    preload(8'h20, 8'h11);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].is_data, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd_cnt, wr_cnt, got_err, other_cnt);
      nm = $sformatf("v%0d", i);
      chk({nm, "_latency"}, lat, 4);
      chk({nm, "_err"}, got_err, 0);
      chk({nm, "_other_done"}, other_cnt, 0);
      chk({nm, "_read_cycles"}, rd_cnt, (vecs[i].is_data && vecs[i].we) ? 0 : 2);
      chk({nm, "_write_cycles"}, wr_cnt, (vecs[i].is_data && vecs[i].we) ? 2 : 0);
      chk({nm, "_grant"}, grant, vecs[i].is_data);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_address"}, mem_address, vecs[i].addr);
      chk({nm, "_wval"}, mem_write_value, (vecs[i].is_data && vecs[i].we) ? vecs[i].wdata : 8'h00);
      chk({nm, "_rdata"}, vecs[i].is_data ? d_rdata : f_rdata, vecs[i].exp_rdata);
    end

    // both requesters waiting as reset releases, each held for two transactions
    #2 reset_n = 1'b0;
    f_req = 1'b1; f_addr = 8'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h66;
    @(negedge clk) reset_n = 1'b1;
    n = 0; fcnt = 0; dcnt = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(posedge clk); #1;
      if (f_done && n < 4) begin
        order[n] = 0; gnts[n] = int'(grant); n++; fcnt++;
        if (fcnt == 2) f_req = 1'b0;
      end
      if (d_done && n < 4) begin
        order[n] = 1; gnts[n] = int'(grant); n++; dcnt++;
        if (dcnt == 2) d_req = 1'b0;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    chk("rr_count", n, 4);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("rr_order%0d", k), order[k], k % 2);
      chk($sformatf("rr_grant%0d", k), gnts[k], k % 2);
    end
    chk("rr_f_rdata", f_rdata, 8'hC3);
    chk("rr_d_rdata", d_rdata, 8'h5A);

    // requester keeps req high through done, drops it one cycle later
    repeat (2) @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (d_done) begin cnt = 1; break; end
    end
    chk("hold_done_seen", cnt, 1);
    chk("hold_rdata", d_rdata, 8'hC3);
    @(posedge clk); #1;
    d_req = 1'b0;
    cnt = int'(busy) + int'(d_done);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      cnt += int'(busy) + int'(d_done);
    end
    chk("hold_no_duplicate", cnt, 0);

    // reset pulse while a write strobe is up
    repeat (2) @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h77;
    @(posedge clk); #1;
    chk("arst_write_up", mem_write, 1);
    chk("arst_busy_up", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_write_drop", mem_write, 0);
    chk("arst_busy_drop", busy, 0);
    chk("arst_no_done", d_done, 0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      cnt += int'(d_done) + int'(busy);
    end
    chk("arst_quiet_after", cnt, 0);
    do_txn(1'b1, 1'b0, 8'h20, 8'h00, lat, rd_cnt, wr_cnt, got_err, other_cnt);
    chk("arst_fresh_latency", lat, 4);
    chk("arst_fresh_rdata", d_rdata, 8'h11);

`ifdef MEM_ARB_TIMEOUT_EN
    stuck = 1'b1;
    do_txn(1'b1, 1'b0, 8'h10, 8'h00, lat, rd_cnt, wr_cnt, got_err, other_cnt);
    chk("to_latency", lat, TO);
    chk("to_err", got_err, 1);
    chk("to_done_absent", d_done, 0);
    chk("to_read_cycles", rd_cnt, TO);
    chk("to_strobe_drop", mem_read, 0);
    chk("to_busy", busy, 0);
    stuck = 1'b0;
    do_txn(1'b0, 1'b0, 8'h66, 8'h00, lat, rd_cnt, wr_cnt, got_err, other_cnt);
    chk("to_next_latency", lat, 4);
    chk("to_next_err", got_err, 0);
    chk("to_next_rdata", f_rdata, 8'h5A);
`endif

    chk("no_both_strobes", excl_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
